// File: rtl/data_mem_pkg.sv
// data_mem_pkg
// Shared constants and types for the data-memory responder slice.
// Holds the MMIO register offsets, the console status bit positions and the
// region-decode enum used by the top-level address decoder.
package data_mem_pkg;

    // Byte offsets of the console registers inside the MMIO window
    localparam logic [31:0] CONS_TX_OFFSET     = 32'h0000_0000;
    localparam logic [31:0] CONS_STATUS_OFFSET = 32'h0000_0004;

    // Bit positions inside the CONS_STATUS read word
    localparam int STATUS_EMPTY    = 0;
    localparam int STATUS_FULL     = 1;
    localparam int STATUS_OVERFLOW = 2;

    // Which target a core request lands on
    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_CONS_TX,
        REGION_CONS_STATUS,
        REGION_UNMAPPED
    } region_e;

endpackage

// File: rtl/data_mem_responder_console_tx_fifo.sv
// console_tx_fifo
// Byte-wide transmit FIFO behind the console MMIO register.
// Ports:
//   clk, reset        falling-edge clock, asynchronous active-low reset
//   push, push_data   byte offered by a CONS_TX store
//   pop               sink consumed the head byte this cycle
//   clear_overflow    CONS_STATUS write clears the sticky overflow flag
//   head              byte at the FIFO head
//   full, empty       occupancy flags (state before the current edge)
//   overflow          sticky flag: a push was dropped because the FIFO was full
module console_tx_fifo #(
    parameter int CONS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       clear_overflow,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int PW = $clog2(CONS_DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [7:0]    entries [CONS_DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full  = (count == (PW+1)'(CONS_DEPTH));
    assign empty = (count == '0);
    assign head  = entries[rd_ptr];

    // A push into a full FIFO still fits when the head leaves on the same edge
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers wrap naturally because the depth is a power of two; the
    // overflow set takes priority over a same-cycle clear so a dropped byte
    // is never hidden.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !do_pop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage carries no reset; only entries between the pointers are meaningful
    always_ff @(negedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Responder end of the core data-memory interface: word-addressed RAM, a
// console transmit FIFO in a small MMIO window, and a loader port for filling
// RAM. All state changes on the falling edge of clk; all outputs are
// combinational so loads complete in the same cycle they are requested.
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   data_addr, should_read_mem,
//   should_write_mem,
//   mem_write_data               core request
//   mem_read_data, access_fault  core response
//   load_valid/ready/addr/data   loader write port (core store wins)
//   cons_valid/ready/data        console byte stream
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          CONS_DEPTH  = 4,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    data_addr,
    input  logic                           should_read_mem,
    input  logic                           should_write_mem,
    input  logic [31:0]                    mem_write_data,
    output logic [31:0]                    mem_read_data,
    output logic                           access_fault,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data,
    output logic                           cons_valid,
    input  logic                           cons_ready,
    output logic [7:0]                     cons_data
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   ram [DEPTH_WORDS];
    region_e       region;
    logic [AW-1:0] word_idx;
    logic          any_req;
    logic          good_store;
    logic          store_ram;
    logic          cons_push;
    logic          cons_clear;
    logic          cons_pop;
    logic          cons_full;
    logic          cons_empty;
    logic          cons_overflow;
    logic [31:0]   status_word;

    assign word_idx = data_addr[AW+1:2];

    always_comb begin
        region = REGION_UNMAPPED;
        if (data_addr < RAM_BYTES) begin
            region = REGION_RAM;
        end else if (data_addr == MMIO_BASE + CONS_TX_OFFSET) begin
            region = REGION_CONS_TX;
        end else if (data_addr == MMIO_BASE + CONS_STATUS_OFFSET) begin
            region = REGION_CONS_STATUS;
        end
    end

    // A fault is only meaningful while the core is actually asking for something
    assign any_req      = should_read_mem | should_write_mem;
    assign access_fault = any_req & ((data_addr[1:0] != 2'b00) | (region == REGION_UNMAPPED));

    // A read+write request is a store; the read path still shows old contents
    assign good_store = should_write_mem & ~access_fault;
    assign store_ram  = good_store & (region == REGION_RAM);
    assign cons_push  = good_store & (region == REGION_CONS_TX);
    assign cons_clear = good_store & (region == REGION_CONS_STATUS);

    // The core never stalls, so the loader backs off whenever the core
    // is writing RAM in the same cycle.
    assign load_ready = reset & ~store_ram;

    always_comb begin
        status_word                  = '0;
        status_word[STATUS_EMPTY]    = cons_empty;
        status_word[STATUS_FULL]     = cons_full;
        status_word[STATUS_OVERFLOW] = cons_overflow;
    end

    always_comb begin
        mem_read_data = '0;
        if (should_read_mem && !access_fault) begin
            case (region)
                REGION_RAM:         mem_read_data = ram[word_idx];
                REGION_CONS_STATUS: mem_read_data = status_word;
                default:            mem_read_data = '0;
            endcase
        end
    end

    // RAM is not reset, but a falling edge seen while reset is held must not
    // write it. The core and loader never collide because load_ready drops.
    always_ff @(negedge clk) begin
        if (reset) begin
            if (store_ram) begin
                ram[word_idx] <= mem_write_data;
            end else if (load_valid && load_ready) begin
                ram[load_addr] <= load_data;
            end
        end
    end

    assign cons_valid = reset & ~cons_empty;
    assign cons_pop   = cons_valid & cons_ready;

    console_tx_fifo #(
        .CONS_DEPTH(CONS_DEPTH)
    ) u_cons_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (cons_push),
        .push_data     (mem_write_data[7:0]),
        .pop           (cons_pop),
        .clear_overflow(cons_clear),
        .head          (cons_data),
        .full          (cons_full),
        .empty         (cons_empty),
        .overflow      (cons_overflow)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Directed bench for data_mem_responder. Inputs change just after the rising
// edge and outputs are sampled 1ns later, well before the falling edge where
// the design commits state. Console bytes go through a small queue model.
module tb_data_mem_responder;

    localparam int          DEPTH_WORDS = 1024;
    localparam int          CONS_DEPTH  = 4;
    localparam logic [31:0] MMIO_BASE   = 32'h1000_0000;
    localparam logic [31:0] TX_ADDR     = MMIO_BASE;
    localparam logic [31:0] STAT_ADDR   = MMIO_BASE + 32'h4;

    logic        clk;
    logic        reset;
    logic [31:0] data_addr;
    logic        should_read_mem;
    logic        should_write_mem;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        access_fault;
    logic        load_valid;
    logic        load_ready;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic        cons_valid;
    logic        cons_ready;
    logic [7:0]  cons_data;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  cons_q[$];
    logic        model_ovf = 1'b0;

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .CONS_DEPTH (CONS_DEPTH),
        .MMIO_BASE  (MMIO_BASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .data_addr       (data_addr),
        .should_read_mem (should_read_mem),
        .should_write_mem(should_write_mem),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .access_fault    (access_fault),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .cons_valid      (cons_valid),
        .cons_ready      (cons_ready),
        .cons_data       (cons_data)
    );

    // Free-running clock: rising edges at 5,15,..., falling edges at 10,20,...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something keeps the sequence from finishing
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare the console head against the oldest byte the model expects
    task automatic checkCons(input string tag);
        logic [7:0] exp_byte;
        if (cons_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s observed=pop expected=empty_model", tag);
        end else begin
            exp_byte = cons_q.pop_front();
            checkOutput({tag, "_valid"}, {31'b0, cons_valid}, 32'h1);
            checkOutput({tag, "_data"}, {24'b0, cons_data}, {24'b0, exp_byte});
        end
    endtask

    function automatic logic [31:0] expStatus();
        return {29'b0, model_ovf, cons_q.size() == CONS_DEPTH, cons_q.size() == 0};
    endfunction

    task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                                 input logic [31:0] wdata, input logic lv, input logic [9:0] la,
                                 input logic [31:0] ld, input logic cr);
        @(posedge clk);
        data_addr        = addr;
        should_read_mem  = rd;
        should_write_mem = wr;
        mem_write_data   = wdata;
        load_valid       = lv;
        load_addr        = la;
        load_data        = ld;
        cons_ready       = cr;
        #1;
    endtask

    task automatic idleStep(input logic cr);
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0, cr);
    endtask

    task automatic readStep(input logic [31:0] addr);
        applyStimulus(addr, 1'b1, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0, 1'b0);
    endtask

    task automatic writeStep(input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(addr, 1'b0, 1'b1, wdata, 1'b0, 10'd0, 32'h0, 1'b0);
    endtask

    // Push one byte to CONS_TX and update the model: a same-cycle pop frees a
    // slot, otherwise a push into a full FIFO is dropped and flags overflow.
    task automatic pushCons(input logic [7:0] ch, input logic cr);
        int size_before;
        size_before = cons_q.size();
        applyStimulus(TX_ADDR, 1'b0, 1'b1, {24'hFFFFFF, ch}, 1'b0, 10'd0, 32'h0, cr);
        checkOutput("push_valid", {31'b0, cons_valid}, {31'b0, size_before > 0});
        checkOutput("push_fault", {31'b0, access_fault}, 32'h0);
        if (cr && size_before > 0) begin
            checkCons("push_pop");
        end
        if (cons_q.size() < CONS_DEPTH) begin
            cons_q.push_back(ch);
        end else begin
            model_ovf = 1'b1;
        end
    endtask

    // Pull everything the model holds, then confirm the stream goes quiet
    task automatic drainCons();
        int n;
        n = cons_q.size();
        for (int i = 0; i < n; i++) begin
            idleStep(1'b1);
            checkCons("drain");
        end
        idleStep(1'b0);
        checkOutput("drain_empty", {31'b0, cons_valid}, 32'h0);
    endtask

    // Directed sequence: reset, loader, priority, console, faults
    initial begin
        reset            = 1'b0;
        data_addr        = 32'h0;
        should_read_mem  = 1'b0;
        should_write_mem = 1'b0;
        mem_write_data   = 32'h0;
        load_valid       = 1'b1;
        load_addr        = 10'd3;
        load_data        = 32'h0;
        cons_ready       = 1'b0;

        @(posedge clk);
        #1;
        checkOutput("reset_cons_valid", {31'b0, cons_valid}, 32'h0);
        checkOutput("reset_load_ready", {31'b0, load_ready}, 32'h0);
        idleStep(1'b0);
        reset = 1'b1;

        readStep(STAT_ADDR);
        checkOutput("status_after_reset", mem_read_data, 32'h1);
        checkOutput("status_fault", {31'b0, access_fault}, 32'h0);
        readStep(TX_ADDR);
        checkOutput("tx_read_zero", mem_read_data, 32'h0);

        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0);
        checkOutput("loader_ready", {31'b0, load_ready}, 32'h1);
        readStep(32'h14);
        checkOutput("loader_read", mem_read_data, 32'hDEAD_BEEF);
        checkOutput("loader_read_fault", {31'b0, access_fault}, 32'h0);

        applyStimulus(32'h20, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 10'd8, 32'hCAFE_F00D, 1'b0);
        checkOutput("prio_load_ready", {31'b0, load_ready}, 32'h0);
        applyStimulus(32'h20, 1'b1, 1'b0, 32'h0, 1'b1, 10'd8, 32'hCAFE_F00D, 1'b0);
        checkOutput("prio_core_won", mem_read_data, 32'h1234_5678);
        checkOutput("retry_load_ready", {31'b0, load_ready}, 32'h1);
        readStep(32'h20);
        checkOutput("retry_committed", mem_read_data, 32'hCAFE_F00D);

        applyStimulus(32'h20, 1'b1, 1'b1, 32'h0000_0055, 1'b0, 10'd0, 32'h0, 1'b0);
        checkOutput("rw_pre_write", mem_read_data, 32'hCAFE_F00D);
        readStep(32'h20);
        checkOutput("rw_stored", mem_read_data, 32'h0000_0055);

        writeStep(32'hFFC, 32'hA5A5_0001);
        checkOutput("last_word_fault", {31'b0, access_fault}, 32'h0);
        readStep(32'hFFC);
        checkOutput("last_word_read", mem_read_data, 32'hA5A5_0001);
        readStep(32'h1000);
        checkOutput("past_ram_fault", {31'b0, access_fault}, 32'h1);
        checkOutput("past_ram_data", mem_read_data, 32'h0);

        // Reset with bytes queued and a store pending
        writeStep(32'h30, 32'h1111_2222);
        writeStep(32'h0, 32'h0BAD_F00D);
        pushCons("a", 1'b0);
        pushCons("b", 1'b0);
        pushCons("c", 1'b0);
        idleStep(1'b0);
        checkOutput("queued_head", {24'b0, cons_data}, {24'b0, cons_q[0]});
        reset = 1'b0;
        applyStimulus(32'h30, 1'b0, 1'b1, 32'hBADB_AD00, 1'b1, 10'd9, 32'h9999_9999, 1'b0);
        checkOutput("midreset_cons_valid", {31'b0, cons_valid}, 32'h0);
        checkOutput("midreset_load_ready", {31'b0, load_ready}, 32'h0);
        idleStep(1'b0);
        reset = 1'b1;
        cons_q.delete();
        model_ovf = 1'b0;
        readStep(STAT_ADDR);
        checkOutput("status_post_reset", mem_read_data, expStatus());
        checkOutput("post_reset_cons_valid", {31'b0, cons_valid}, 32'h0);
        readStep(32'h30);
        checkOutput("no_write_in_reset", mem_read_data, 32'h1111_2222);

        // Overflow: fifth byte is dropped
        pushCons("A", 1'b0);
        pushCons("B", 1'b0);
        pushCons("C", 1'b0);
        pushCons("D", 1'b0);
        pushCons("E", 1'b0);
        readStep(STAT_ADDR);
        checkOutput("status_full_ovf", mem_read_data, 32'h6);
        checkOutput("status_model_ovf", mem_read_data, expStatus());
        drainCons();
        readStep(STAT_ADDR);
        checkOutput("status_empty_ovf", mem_read_data, 32'h5);
        writeStep(STAT_ADDR, 32'h0);
        model_ovf = 1'b0;
        readStep(STAT_ADDR);
        checkOutput("status_cleared", mem_read_data, 32'h1);

        // Full FIFO with simultaneous push and pop
        pushCons("P", 1'b0);
        pushCons("Q", 1'b0);
        pushCons("R", 1'b0);
        pushCons("S", 1'b0);
        pushCons("X", 1'b1);
        readStep(STAT_ADDR);
        checkOutput("status_full_no_ovf", mem_read_data, 32'h2);
        drainCons();
        readStep(STAT_ADDR);
        checkOutput("status_after_pushpop", mem_read_data, 32'h1);

        // Faults
        readStep(32'h21);
        checkOutput("misaligned_fault", {31'b0, access_fault}, 32'h1);
        checkOutput("misaligned_data", mem_read_data, 32'h0);
        writeStep(32'h2000_0000, 32'hFFFF_FFFF);
        checkOutput("unmapped_fault", {31'b0, access_fault}, 32'h1);
        checkOutput("unmapped_load_ready", {31'b0, load_ready}, 32'h1);
        readStep(32'h0);
        checkOutput("unmapped_no_alias", mem_read_data, 32'h0BAD_F00D);
        writeStep(32'h22, 32'hFFFF_FFFF);
        checkOutput("misaligned_wr_fault", {31'b0, access_fault}, 32'h1);
        readStep(32'h20);
        checkOutput("misaligned_wr_blocked", mem_read_data, 32'h0000_0055);
        writeStep(MMIO_BASE + 32'h1, 32'h0000_005A);
        checkOutput("mmio_misaligned_fault", {31'b0, access_fault}, 32'h1);
        readStep(MMIO_BASE + 32'h8);
        checkOutput("mmio_hole_fault", {31'b0, access_fault}, 32'h1);
        checkOutput("mmio_hole_no_push", {31'b0, cons_valid}, 32'h0);
        applyStimulus(32'h21, 1'b0, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0, 1'b0);
        checkOutput("idle_no_fault", {31'b0, access_fault}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
